// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the single register-file write port between the in-order
// writeback stage and a FIFO of multiply/divide results. The granted write is
// registered onto rf_* so those outputs can also feed the bypass network.
// A starvation counter forces a FIFO drain (stalling writeback) when the FIFO
// has been passed over for STARVE_MAX consecutive cycles.
// Optional feature: define WB_ARB_BYPASS_EN to let an MDU result go straight
// to the write port when the FIFO is empty and writeback is idle.
module wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     pipe_valid,
  input  logic [4:0]               pipe_wa,
  input  logic [63:0]              pipe_wd,
  output logic                     pipe_stall,
  input  logic                     mdu_valid,
  input  logic [4:0]               mdu_wa,
  input  logic [63:0]              mdu_wd,
  output logic                     mdu_ready,
  output logic                     rf_we,
  output logic [4:0]               rf_wa,
  output logic [63:0]              rf_wd,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  // FIFO is kept compacted: entry 0 is always the head, entries
  // [0, cnt_r) are live. Compaction makes WAW invalidation of arbitrary
  // entries cheap to express and keeps fifo_cnt equal to live entries.
  logic [4:0]    fifo_wa_r [DEPTH];
  logic [63:0]   fifo_wd_r [DEPTH];
  logic [CW-1:0] cnt_r;
  logic [SW-1:0] starve_r;

  logic          fifo_ne_s;
  logic          force_s;
  logic          grant_s;
  logic [4:0]    gwa_s;
  logic [63:0]   gwd_s;
  logic          pop_s;
  logic          inval_s;
  logic          byp_s;
  logic          push_s;
  logic [4:0]    nxt_wa_s [DEPTH];
  logic [63:0]   nxt_wd_s [DEPTH];
  logic [CW-1:0] k_s;
  logic [SW-1:0] starve_nxt_s;

  assign fifo_ne_s = (cnt_r != {CW{1'b0}});
  assign force_s   = fifo_ne_s && (starve_r == SW'(STARVE_MAX));
  assign fifo_cnt  = cnt_r;
  // A full FIFO is never ready, even when it pops this cycle.
  assign mdu_ready = (cnt_r < CW'(DEPTH));
  assign push_s    = mdu_valid && mdu_ready && !byp_s;

  // Priority arbitration: forced drain, pipeline, FIFO head, optional bypass.
  always_comb begin
    grant_s    = 1'b0;
    gwa_s      = 5'd0;
    gwd_s      = 64'd0;
    pop_s      = 1'b0;
    inval_s    = 1'b0;
    byp_s      = 1'b0;
    pipe_stall = 1'b0;
    if (force_s) begin
      grant_s    = 1'b1;
      gwa_s      = fifo_wa_r[0];
      gwd_s      = fifo_wd_r[0];
      pop_s      = 1'b1;
      pipe_stall = pipe_valid;
    end else if (pipe_valid) begin
      grant_s = 1'b1;
      gwa_s   = pipe_wa;
      gwd_s   = pipe_wd;
      inval_s = 1'b1;
    end else if (fifo_ne_s) begin
      grant_s = 1'b1;
      gwa_s   = fifo_wa_r[0];
      gwd_s   = fifo_wd_r[0];
      pop_s   = 1'b1;
    end else begin
`ifdef WB_ARB_BYPASS_EN
      if (mdu_valid) begin
        grant_s = 1'b1;
        gwa_s   = mdu_wa;
        gwd_s   = mdu_wd;
        byp_s   = 1'b1;
      end else begin
        grant_s = 1'b0;
      end
`else
      grant_s = 1'b0;
`endif
    end
  end

  // Next FIFO contents: drop popped head and entries overwritten by a younger
  // pipeline write, compact the survivors, then append any push at the tail.
  always_comb begin
    k_s      = {CW{1'b0}};
    nxt_wa_s = fifo_wa_r;
    nxt_wd_s = fifo_wd_r;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < cnt_r) &&
          !(pop_s && (CW'(i) == {CW{1'b0}})) &&
          !(inval_s && (fifo_wa_r[i] == pipe_wa))) begin
        nxt_wa_s[k_s[AW-1:0]] = fifo_wa_r[i];
        nxt_wd_s[k_s[AW-1:0]] = fifo_wd_r[i];
        k_s = k_s + CW'(1);
      end else begin
        k_s = k_s;
      end
    end
    if (push_s) begin
      nxt_wa_s[k_s[AW-1:0]] = mdu_wa;
      nxt_wd_s[k_s[AW-1:0]] = mdu_wd;
      k_s = k_s + CW'(1);
    end else begin
      k_s = k_s;
    end
  end

  // Starvation counter: counts cycles the live head is passed over, saturating.
  always_comb begin
    if (!fifo_ne_s || pop_s) begin
      starve_nxt_s = {SW{1'b0}};
    end else if (starve_r < SW'(STARVE_MAX)) begin
      starve_nxt_s = starve_r + SW'(1);
    end else begin
      starve_nxt_s = starve_r;
    end
  end

  // State and registered write-port update; reset drops everything in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r    <= {CW{1'b0}};
      starve_r <= {SW{1'b0}};
      rf_we    <= 1'b0;
      rf_wa    <= 5'd0;
      rf_wd    <= 64'd0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_wa_r[i] <= 5'd0;
        fifo_wd_r[i] <= 64'd0;
      end
    end else begin
      cnt_r     <= k_s;
      starve_r  <= starve_nxt_s;
      fifo_wa_r <= nxt_wa_s;
      fifo_wd_r <= nxt_wd_s;
      // Writes to r0 still use the slot but never assert the enable.
      rf_we     <= grant_s && (gwa_s != 5'd0);
      if (grant_s) begin
        rf_wa <= gwa_s;
        rf_wd <= gwd_s;
      end else begin
        rf_wa <= rf_wa;
        rf_wd <= rf_wd;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter (DEPTH=2, STARVE_MAX=4): a cycle table of inputs
// with expected combinational outputs for that cycle and registered outputs
// after the following rising edge, plus hand-written reset/latency sequences.
module tb_wb_arbiter;

  logic        clk;
  logic        resetn;
  logic        pipe_valid;
  logic [4:0]  pipe_wa;
  logic [63:0] pipe_wd;
  logic        pipe_stall;
  logic        mdu_valid;
  logic [4:0]  mdu_wa;
  logic [63:0] mdu_wd;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [63:0] rf_wd;
  logic [1:0]  fifo_cnt;

  int checks;
  int errors;

  wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pipe_valid (pipe_valid),
    .pipe_wa    (pipe_wa),
    .pipe_wd    (pipe_wd),
    .pipe_stall (pipe_stall),
    .mdu_valid  (mdu_valid),
    .mdu_wa     (mdu_wa),
    .mdu_wd     (mdu_wd),
    .mdu_ready  (mdu_ready),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .fifo_cnt   (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [4:0]  pwa;
    logic [63:0] pwd;
    logic        mv;
    logic [4:0]  mwa;
    logic [63:0] mwd;
    logic        stall;
    logic        ready;
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [1:0]  cnt;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic pv, input logic [4:0] pwa, input logic [63:0] pwd,
                        input logic mv, input logic [4:0] mwa, input logic [63:0] mwd);
    pipe_valid = pv;  pipe_wa = pwa;  pipe_wd = pwd;
    mdu_valid  = mv;  mdu_wa  = mwa;  mdu_wd  = mwd;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    set_in(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);

    // ---------------- reset values ----------------
    repeat (2) @(posedge clk);
    #1;
    check("reset rf_we", {63'd0, rf_we}, 64'd0);
    check("reset rf_wa", {59'd0, rf_wa}, 64'd0);
    check("reset rf_wd", rf_wd, 64'd0);
    check("reset fifo_cnt", {62'd0, fifo_cnt}, 64'd0);
    check("reset mdu_ready", {63'd0, mdu_ready}, 64'd1);
    check("reset pipe_stall", {63'd0, pipe_stall}, 64'd0);
    resetn = 1'b1;
    tick();
    check("idle rf_we", {63'd0, rf_we}, 64'd0);

    // ---------------- cycle table ----------------
    //            pv    pwa    pwd         mv    mwa    mwd        stall ready we    wa     wd          cnt
    // pipeline write, then idle
    vq.push_back('{1'b1, 5'd5,  64'h1234, 1'b0, 5'd0,  64'h0,   1'b0, 1'b1, 1'b1, 5'd5,  64'h1234, 2'd0});
    vq.push_back('{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,   1'b0, 1'b1, 1'b0, 5'd0,  64'h0,    2'd0});
    // starvation: one entry, pipeline busy every cycle; forced drain on 5th eligible cycle
    vq.push_back('{1'b0, 5'd0,  64'h0,    1'b1, 5'd7,  64'hAA,  1'b0, 1'b1, 1'b0, 5'd0,  64'h0,    2'd1});
    vq.push_back('{1'b1, 5'd1,  64'h11,   1'b0, 5'd0,  64'h0,   1'b0, 1'b1, 1'b1, 5'd1,  64'h11,   2'd1});
    vq.push_back('{1'b1, 5'd2,  64'h22,   1'b0, 5'd0,  64'h0,   1'b0, 1'b1, 1'b1, 5'd2,  64'h22,   2'd1});
    vq.push_back('{1'b1, 5'd3,  64'h33,   1'b0, 5'd0,  64'h0,   1'b0, 1'b1, 1'b1, 5'd3,  64'h33,   2'd1});
    vq.push_back('{1'b1, 5'd4,  64'h44,   1'b0, 5'd0,  64'h0,   1'b0, 1'b1, 1'b1, 5'd4,  64'h44,   2'd1});
    vq.push_back('{1'b1, 5'd6,  64'h66,   1'b0, 5'd0,  64'h0,   1'b1, 1'b1, 1'b1, 5'd7,  64'hAA,   2'd0});
    vq.push_back('{1'b1, 5'd6,  64'h66,   1'b0, 5'd0,  64'h0,   1'b0, 1'b1, 1'b1, 5'd6,  64'h66,   2'd0});
    // fill to full, ready drops, held mdu_valid pushes only after a pop frees a slot
    vq.push_back('{1'b1, 5'd11, 64'h111,  1'b1, 5'd10, 64'h100, 1'b0, 1'b1, 1'b1, 5'd11, 64'h111,  2'd1});
    vq.push_back('{1'b1, 5'd13, 64'h131,  1'b1, 5'd12, 64'h200, 1'b0, 1'b1, 1'b1, 5'd13, 64'h131,  2'd2});
    vq.push_back('{1'b0, 5'd0,  64'h0,    1'b1, 5'd14, 64'h300, 1'b0, 1'b0, 1'b1, 5'd10, 64'h100,  2'd1});
    vq.push_back('{1'b0, 5'd0,  64'h0,    1'b1, 5'd14, 64'h300, 1'b0, 1'b1, 1'b1, 5'd12, 64'h200,  2'd1});
    vq.push_back('{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,   1'b0, 1'b1, 1'b1, 5'd14, 64'h300,  2'd0});
    vq.push_back('{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,   1'b0, 1'b1, 1'b0, 5'd0,  64'h0,    2'd0});
    // WAW: younger pipeline write to r9 discards the buffered r9 result
    vq.push_back('{1'b0, 5'd0,  64'h0,    1'b1, 5'd9,  64'h999, 1'b0, 1'b1, 1'b0, 5'd0,  64'h0,    2'd1});
    vq.push_back('{1'b1, 5'd9,  64'hBEEF, 1'b0, 5'd0,  64'h0,   1'b0, 1'b1, 1'b1, 5'd9,  64'hBEEF, 2'd0});
    vq.push_back('{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,   1'b0, 1'b1, 1'b0, 5'd0,  64'h0,    2'd0});
    // writes to r0: slot consumed, FIFO popped, no enable
    vq.push_back('{1'b1, 5'd0,  64'h55,   1'b0, 5'd0,  64'h0,   1'b0, 1'b1, 1'b0, 5'd0,  64'h0,    2'd0});
    vq.push_back('{1'b0, 5'd0,  64'h0,    1'b1, 5'd0,  64'h66,  1'b0, 1'b1, 1'b0, 5'd0,  64'h0,    2'd1});
    vq.push_back('{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,   1'b0, 1'b1, 1'b0, 5'd0,  64'h0,    2'd0});
    // WAW on the head with a survivor behind it
    vq.push_back('{1'b0, 5'd0,  64'h0,    1'b1, 5'd20, 64'hA0,  1'b0, 1'b1, 1'b0, 5'd0,  64'h0,    2'd1});
    vq.push_back('{1'b1, 5'd30, 64'hB0,   1'b1, 5'd21, 64'hA1,  1'b0, 1'b1, 1'b1, 5'd30, 64'hB0,   2'd2});
    vq.push_back('{1'b1, 5'd20, 64'hC0,   1'b0, 5'd0,  64'h0,   1'b0, 1'b0, 1'b1, 5'd20, 64'hC0,   2'd1});
    vq.push_back('{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,   1'b0, 1'b1, 1'b1, 5'd21, 64'hA1,   2'd0});

    foreach (vq[i]) begin
      set_in(vq[i].pv, vq[i].pwa, vq[i].pwd, vq[i].mv, vq[i].mwa, vq[i].mwd);
      #1;
      check($sformatf("row%0d pipe_stall", i), {63'd0, pipe_stall}, {63'd0, vq[i].stall});
      check($sformatf("row%0d mdu_ready", i), {63'd0, mdu_ready}, {63'd0, vq[i].ready});
      tick();
      check($sformatf("row%0d rf_we", i), {63'd0, rf_we}, {63'd0, vq[i].we});
      if (vq[i].we) begin
        check($sformatf("row%0d rf_wa", i), {59'd0, rf_wa}, {59'd0, vq[i].wa});
        check($sformatf("row%0d rf_wd", i), rf_wd, vq[i].wd);
      end
      check($sformatf("row%0d fifo_cnt", i), {62'd0, fifo_cnt}, {62'd0, vq[i].cnt});
    end

    // ---------------- MDU-to-write latency ----------------
    set_in(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'hAA);
    tick();
    set_in(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
`ifdef WB_ARB_BYPASS_EN
    check("bypass rf_we", {63'd0, rf_we}, 64'd1);
    check("bypass rf_wa", {59'd0, rf_wa}, 64'd7);
    check("bypass fifo_cnt", {62'd0, fifo_cnt}, 64'd0);
    tick();
    check("bypass rf_we pulse", {63'd0, rf_we}, 64'd0);
`else
    check("mdu lat1 rf_we", {63'd0, rf_we}, 64'd0);
    check("mdu lat1 fifo_cnt", {62'd0, fifo_cnt}, 64'd1);
    tick();
    check("mdu lat2 rf_we", {63'd0, rf_we}, 64'd1);
    check("mdu lat2 rf_wa", {59'd0, rf_wa}, 64'd7);
    check("mdu lat2 rf_wd", rf_wd, 64'hAA);
    tick();
    check("mdu lat3 rf_we", {63'd0, rf_we}, 64'd0);
`endif

    // ---------------- reset mid-drain with two entries ----------------
    set_in(1'b1, 5'd4, 64'h4, 1'b1, 5'd3, 64'h3);
    tick();
    set_in(1'b1, 5'd6, 64'h6, 1'b1, 5'd5, 64'h5);
    tick();
    check("pre-drain fifo_cnt", {62'd0, fifo_cnt}, 64'd2);
    set_in(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    tick();
    check("drain rf_we", {63'd0, rf_we}, 64'd1);
    check("drain rf_wa", {59'd0, rf_wa}, 64'd3);
    resetn = 1'b0;
    #1;
    check("mid rst rf_we", {63'd0, rf_we}, 64'd0);
    check("mid rst rf_wa", {59'd0, rf_wa}, 64'd0);
    check("mid rst rf_wd", rf_wd, 64'd0);
    check("mid rst fifo_cnt", {62'd0, fifo_cnt}, 64'd0);
    check("mid rst mdu_ready", {63'd0, mdu_ready}, 64'd1);
    tick();
    resetn = 1'b1;
    tick();
    check("post rst rf_we", {63'd0, rf_we}, 64'd0);
    check("post rst fifo_cnt", {62'd0, fifo_cnt}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
